dff_pipe: RTL

DFF_PIPE -- requirements
Module: dff_pipe

---
 rtl/dff_pipe_pkg.sv | 27 ++
 rtl/dff_pipe_stage.sv | 48 ++++
 rtl/dff_pipe.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dff_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dff_pipe_pkg
// Description : Shared helpers for the dff_pipe register pipeline.
//               - even_parity : parity bit that makes the total number of
//                               ones in {word, bit} even (the XOR of the word)
//               - count_width : width of the occupancy counter for a given
//                               number of stages
// Revision    : 1.0 - initial release
// ============================================================================
package dff_pipe_pkg;

    // Widest data word the pipeline supports; callers zero-extend narrower
    // words into this width, which leaves the parity unchanged.
    localparam int MAX_WIDTH = 64;

    function automatic logic even_parity(input logic [MAX_WIDTH-1:0] word);
        return ^word;
    endfunction

    // The counter must be able to hold the value DEPTH itself.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dff_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : dff_pipe_stage
// Description : One pipeline register: a data word plus its valid flag.
//               When adv is high the stage takes whatever the upstream side
//               offers (up_valid/up_data); the data flops load only when a
//               real word arrives, so an empty slot keeps its old contents.
//               flush clears the valid flag but never touches the data.
// Ports       : clk      - clock, all updates on the rising edge
//               rst      - synchronous active-high reset
//               flush    - clear valid, keep data
//               adv      - stage may take a new word (empty or emptying)
//               up_valid - upstream offers a word
//               up_data  - upstream word
//               valid    - stage occupied
//               data     - stored word
// Revision    : 1.0 - initial release
// ============================================================================
module dff_pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             adv,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (adv) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dff_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dff_pipe
// Description : Elastic DEPTH-stage register pipeline with valid/ready
//               handshakes on both sides. q/out_valid come straight from the
//               last stage's flops. Empty slots (bubbles) are squeezed out:
//               a stage can take a new word whenever it, or any stage
//               downstream of it, is empty, or the consumer is taking q.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_valid/in_ready/d - producer side
//               out_valid/out_ready/q - consumer side
//               flush               - drop every in-flight word
//               count               - number of occupied stages
//               out_perr            - parity error on q
// Options     : DFF_PIPE_PARITY_EN  - when defined, every stage stores an
//               even-parity bit computed from d on accept and out_perr flags a
//               mismatch on the last stage; otherwise out_perr is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              d,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              q,
    input  logic                          flush,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          out_perr
);

    localparam int CW = count_width(DEPTH);

`ifdef DFF_PIPE_PARITY_EN
    // Parity travels as the MSB of each stage word.
    localparam int            SW        = WIDTH + 1;
    localparam logic [SW-1:0] STAGE_RST = {even_parity(64'(RESET_VAL)), RESET_VAL};
`else
    localparam int            SW        = WIDTH;
    localparam logic [SW-1:0] STAGE_RST = RESET_VAL;
`endif

    logic [SW-1:0]    head_word;
    logic [SW-1:0]    sdata [DEPTH];
    logic [DEPTH-1:0] svalid;
    logic [DEPTH-1:0] sready;
    logic [SW-1:0]    last_word;
    logic             in_fire;
    logic             out_fire;

`ifdef DFF_PIPE_PARITY_EN
    assign head_word = {even_parity(64'(d)), d};
`else
    assign head_word = d;
`endif

    // ------------------------------------------------------------------
    // Stage array. Stage i can take a word when the consumer is draining
    // the last stage or any stage from i to DEPTH-1 is empty: a hole
    // anywhere downstream means every word above it shifts by one. The
    // reduction form avoids a ripple chain through sready itself.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic          up_valid;
        logic [SW-1:0] up_data;

        assign sready[i] = out_ready | ~(&svalid[DEPTH-1:i]);

        if (i == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = head_word;
        end else begin : g_body
            assign up_valid = svalid[i-1];
            assign up_data  = sdata[i-1];
        end

        dff_pipe_stage #(
            .WIDTH     (SW),
            .RESET_VAL (STAGE_RST)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .adv      (sready[i]),
            .up_valid (up_valid),
            .up_data  (up_data),
            .valid    (svalid[i]),
            .data     (sdata[i])
        );
    end

    // in_ready depends only on stage state and out_ready, never on in_valid.
    assign in_ready  = sready[0];
    assign last_word = sdata[DEPTH-1];
    assign out_valid = svalid[DEPTH-1];
    assign q         = last_word[WIDTH-1:0];

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

`ifdef DFF_PIPE_PARITY_EN
    assign out_perr = out_valid & (even_parity(64'(q)) ^ last_word[WIDTH]);
`else
    assign out_perr = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Occupancy counter. Kept as its own register rather than a popcount
    // of svalid so it stays a plain flop output. Accept and output in the
    // same cycle cancel; flush wins over a simultaneous accept.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CW'(in_fire) - CW'(out_fire);
        end
    end

endmodule
`default_nettype wire
